quad_decoder: RTL and testbench

Parametrised quadrature encoder decoder with input synchronisation, glitch filtering, a signed position counter and illegal-transition detection. It replaces the single-purpose per-cycle direction reader in the encoder input path and feeds position, step and direction to the motion/display logic downstream. All outputs are registered and all state is in the `clk` domain. `a` and `b` are asynchronous.

---
 rtl/quad_decoder_if.sv | 17 +
 rtl/quad_decoder.sv | 168 ++++++++++++++++
 tb/tb_quad_decoder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
// Encoder pins and decoded position/step/direction/error bundle.
// The master drives a/b/clr; the decoder (slave) drives the results.
interface quad_decoder_if #(
    parameter int POS_W = 16
);
    logic                    a;
    logic                    b;
    logic                    clr;
    logic signed [POS_W-1:0] pos;
    logic [1:0]              dir;
    logic                    step;
    logic                    err;
    logic [7:0]              err_cnt;

    modport master (output a, b, clr, input pos, dir, step, err, err_cnt);
    modport slave  (input a, b, clr, output pos, dir, step, err, err_cnt);
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchroniser, glitch filter, signed position, illegal-transition count; QDEC_SATURATE_EN clamps pos instead of wrapping.
// Latency: SYNC_STAGES+FILT_LEN+1 edges from the first sample of a stable level to dir/step/err; pos/err_cnt move on that same edge.
// Backpressure: none; levels held for fewer than FILT_LEN cycles are dropped as glitches.
module quad_decoder #(
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input logic           clk,
    input logic           rst_n,
    quad_decoder_if.slave qdec
);
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [SYNC_STAGES-1:0]      sync_fill;
    logic [1:0]                  s;
    logic                        s_ok;

    assign s    = sync_q[SYNC_STAGES-1];
    assign s_ok = sync_fill[SYNC_STAGES-1];

    // sync_fill keeps the reset zeros of the chain from being taken as a real encoder level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_fill <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], {qdec.a, qdec.b}};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    logic [1:0]       q;
    logic [1:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             q_vld;
    logic             q_chg;
    logic             s_new;

    always_comb begin
        s_new   = s_ok && (!q_vld || (s != q));
        cnt_nxt = (s == cand) ? cnt + CNT_W'(1) : CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            cand  <= '0;
            cnt   <= '0;
            q_vld <= 1'b0;
            q_chg <= 1'b0;
        end else begin
            q_chg <= 1'b0;
            if (s_new) begin
                if (cnt_nxt == CNT_W'(FILT_LEN)) begin
                    q     <= s;
                    q_vld <= 1'b1;
                    q_chg <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cand <= s;
                    cnt  <= cnt_nxt;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    logic [1:0] q_prev;
    logic       armed;
    logic       ev_vld;
    logic [3:0] ev_code;

    // The first accepted level only seeds q_prev, so the power-up level never counts as a move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_prev  <= '0;
            armed   <= 1'b0;
            ev_vld  <= 1'b0;
            ev_code <= '0;
        end else begin
            ev_vld  <= q_chg && armed;
            ev_code <= {q_prev, q};
            if (q_chg) begin
                q_prev <= q;
                armed  <= 1'b1;
            end
        end
    end

    logic ev_fwd;
    logic ev_rev;
    logic ev_ill;

    always_comb begin
        ev_fwd = 1'b0;
        ev_rev = 1'b0;
        ev_ill = 1'b0;
        if (ev_vld) begin
            case (ev_code)
                4'b0001, 4'b0111, 4'b1110, 4'b1000: ev_fwd = 1'b1;
                4'b0010, 4'b1011, 4'b1101, 4'b0100: ev_rev = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: ev_ill = 1'b1;
                default: ;
            endcase
        end
    end

    logic signed [POS_W-1:0] pos_r;
    logic signed [POS_W-1:0] pos_inc;
    logic signed [POS_W-1:0] pos_dec;
    logic [1:0]              dir_r;
    logic                    step_r;
    logic                    err_r;
    logic [7:0]              err_cnt_r;

`ifdef QDEC_SATURATE_EN
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    always_comb begin
        pos_inc = (pos_r == POS_MAX) ? pos_r : pos_r + POS_W'(1);
        pos_dec = (pos_r == POS_MIN) ? pos_r : pos_r - POS_W'(1);
    end
`else
    always_comb begin
        pos_inc = pos_r + POS_W'(1);
        pos_dec = pos_r - POS_W'(1);
    end
`endif

    // clr drops the position/error update of a coinciding event but the pulses still go out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r     <= '0;
            dir_r     <= 2'b00;
            step_r    <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            dir_r  <= {ev_fwd, ev_rev};
            step_r <= ev_fwd | ev_rev;
            err_r  <= ev_ill;
            if (qdec.clr) begin
                pos_r     <= '0;
                err_cnt_r <= '0;
            end else begin
                if (ev_fwd) begin
                    pos_r <= pos_inc;
                end else if (ev_rev) begin
                    pos_r <= pos_dec;
                end
                if (ev_ill && (err_cnt_r != 8'hFF)) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end
        end
    end

    assign qdec.pos     = pos_r;
    assign qdec.dir     = dir_r;
    assign qdec.step    = step_r;
    assign qdec.err     = err_r;
    assign qdec.err_cnt = err_cnt_r;
endmodule

// File: tb/tb_quad_decoder.sv
// Randomised and directed bench for quad_decoder against a run-length reference model.
`timescale 1ns/1ps
module tb_quad_decoder;
    localparam int POS_W = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int LAT   = SYNC + FILT + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quad_decoder_if #(.POS_W(POS_W)) qif ();

    quad_decoder #(
        .POS_W      (POS_W),
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .qdec (qif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Encoder phase index: 00=0, 01=1, 11=2, 10=3; forward is +1 mod 4
    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] glvl(input int i);
        case (((i % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int pos_fix(input int v);
        int lo;
        int hi;
        int m;
        lo = -(1 << (POS_W - 1));
        hi = (1 << (POS_W - 1)) - 1;
        m  = 1 << POS_W;
`ifdef QDEC_SATURATE_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        if (hi < lo) return 0;
        return (((v - lo) % m) + m) % m + lo;
`endif
    endfunction

    // Reference model: a run of FILT identical samples that differs from the accepted
    // level is accepted; its move shows up LAT edges after the run's first sample.
    int cyc     = 0;
    int m_pos   = 0;
    int m_errc  = 0;
    bit armed   = 1'b0;
    int acc     = 0;
    int run_val = -1;
    int run_len = 0;
    int due_q[$];
    int kind_q[$];
    int n_step  = 0;
    int n_fwd   = 0;
    int n_err   = 0;

    always @(posedge clk) begin
        int x;
        int e_vec;
        int k;
        cyc++;
        e_vec = 0;
        if (!rst_n) begin
            m_pos   = 0;
            m_errc  = 0;
            armed   = 1'b0;
            run_val = -1;
            run_len = 0;
            due_q.delete();
            kind_q.delete();
        end else begin
            x = gidx({qif.a, qif.b});
            if (x == run_val) begin
                run_len++;
            end else begin
                run_val = x;
                run_len = 1;
            end
            if (run_len == FILT && (!armed || x != acc)) begin
                if (armed) begin
                    due_q.push_back(cyc - FILT + 1 + LAT);
                    kind_q.push_back((x - acc + 4) % 4);
                end
                armed = 1'b1;
                acc   = x;
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                k = kind_q.pop_front();
                if (k == 1) begin
                    e_vec = 4'b1100;
                    m_pos = pos_fix(m_pos + 1);
                end else if (k == 3) begin
                    e_vec = 4'b1010;
                    m_pos = pos_fix(m_pos - 1);
                end else begin
                    e_vec  = 4'b0001;
                    m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                end
            end
            if (qif.clr) begin
                m_pos  = 0;
                m_errc = 0;
            end
        end
        #1;
        chk("step_dir_err", int'({qif.step, qif.dir, qif.err}), e_vec);
        chk("pos", int'($signed(qif.pos)), m_pos);
        chk("err_cnt", int'(qif.err_cnt), m_errc);
        if (qif.step) n_step++;
        if (qif.step && qif.dir == 2'b10) n_fwd++;
        if (qif.err) n_err++;
    end

    int lvl = 0;

    task automatic hold(input int i, input int n);
        {qif.a, qif.b} = glvl(i);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_to(input int d, input int n);
        lvl = lvl + d;
        hold(lvl, n);
    endtask

    initial begin
        int s0;
        int e0;
        int f0;
        int p0;
        int lat;
        int n;
        qif.a   = 1'b1;
        qif.b   = 1'b1;
        qif.clr = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);

        // Power-up at 11 must arm silently
        s0 = n_step;
        e0 = n_err;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("arm_steps", n_step - s0, 0);
        chk("arm_errs", n_err - e0, 0);
        chk("arm_pos", int'($signed(qif.pos)), 0);

        // Forward x8, reverse x3 from 00, with first-step latency
        rst_n = 1'b0;
        lvl = 0;
        hold(lvl, 3);
        rst_n = 1'b1;
        hold(lvl, 10);
        s0 = n_step;
        f0 = n_fwd;
        lvl = 1;
        {qif.a, qif.b} = glvl(lvl);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(posedge clk);
            #2;
            if (qif.step) lat = i;
        end
        chk("first_step_latency", lat, LAT);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) step_to(1, 10);
        for (int i = 0; i < 3; i++) step_to(-1, 10);
        chk("fwdrev_steps", n_step - s0, 11);
        chk("fwdrev_fwd", n_fwd - f0, 8);
        chk("fwdrev_pos", int'($signed(qif.pos)), 5);

        // clr on the same edge as a forward step
        lvl++;
        {qif.a, qif.b} = glvl(lvl);
        repeat (LAT) @(negedge clk);
        qif.clr = 1'b1;
        @(posedge clk);
        #2;
        chk("clr_step", int'(qif.step), 1);
        chk("clr_dir", int'(qif.dir), 2);
        chk("clr_pos", int'($signed(qif.pos)), 0);
        @(negedge clk);
        qif.clr = 1'b0;
        repeat (3) @(negedge clk);
        step_to(1, 10);
        chk("clr_next_pos", int'($signed(qif.pos)), 1);

        // Glitches: 2 cycles rejected, 3 cycles accepted both ways
        s0 = n_step;
        step_to(1, 2);
        step_to(-1, 20);
        chk("glitch2_steps", n_step - s0, 0);
        chk("glitch2_pos", int'($signed(qif.pos)), 1);
        step_to(1, 3);
        step_to(-1, 20);
        chk("glitch3_steps", n_step - s0, 2);
        chk("glitch3_pos", int'($signed(qif.pos)), 1);

        // Illegal transitions and err_cnt saturation
        e0 = n_err;
        p0 = int'($signed(qif.pos));
        step_to(2, 10);
        chk("ill_errs", n_err - e0, 1);
        chk("ill_cnt", int'(qif.err_cnt), 1);
        chk("ill_pos", int'($signed(qif.pos)), p0);
        for (int i = 0; i < 300; i++) step_to(2, FILT + 1);
        hold(lvl, 10);
        chk("ill_sat", int'(qif.err_cnt), 255);
        chk("ill_pulses", n_err - e0, 301);

        // 8 forward steps from 0 on a 4-bit counter
        qif.clr = 1'b1;
        @(negedge clk);
        qif.clr = 1'b0;
        s0 = n_step;
        for (int i = 0; i < 8; i++) step_to(1, 10);
        chk("edge_steps", n_step - s0, 8);
`ifdef QDEC_SATURATE_EN
        chk("sat_pos", int'($signed(qif.pos)), 7);
`else
        chk("wrap_pos", int'($signed(qif.pos)), -8);
`endif

        // Reset with a candidate pending re-arms silently
        s0 = n_step;
        e0 = n_err;
        step_to(1, 2);
        rst_n = 1'b0;
        hold(lvl, 3);
        rst_n = 1'b1;
        hold(lvl, 20);
        chk("rstmid_steps", n_step - s0, 0);
        chk("rstmid_errs", n_err - e0, 0);
        chk("rstmid_pos", int'($signed(qif.pos)), 0);

        // Random levels, hold times, clears and resets
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(1, 6);
            lvl = lvl + $urandom_range(0, 3);
            {qif.a, qif.b} = glvl(lvl);
            if ($urandom_range(0, 15) == 0) begin
                qif.clr = 1'b1;
                @(negedge clk);
                qif.clr = 1'b0;
                n--;
            end else if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                n--;
            end
            repeat (n) @(negedge clk);
        end
        hold(lvl, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
